// File: rtl/if_id_issue_buffer.sv
// if_id_issue_buffer: circular {pc, inst} FIFO between a 2-wide fetch and a 2-wide ID stage.
// Optional macro IBUF_PAIR_CHECK_EN blocks slot 2 when it reads the rd written by slot 1.
module if_id_issue_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_valid_1,
   input  logic [31:0] fetch_inst_1,
   input  logic [31:0] fetch_pc_1,
   input  logic        fetch_valid_2,
   input  logic [31:0] fetch_inst_2,
   input  logic [31:0] fetch_pc_2,
   output logic        fetch_ready,
   input  logic        id_stall,
   input  logic        flush,
   output logic        IF_ID_valid_1,
   output logic [31:0] IF_ID_inst_1,
   output logic [31:0] IF_ID_pc_1,
   output logic [4:0]  IF_ID_rs1_1,
   output logic [4:0]  IF_ID_rs2_1,
   output logic [4:0]  IF_ID_rd_1,
   output logic        IF_ID_valid_2,
   output logic [31:0] IF_ID_inst_2,
   output logic [31:0] IF_ID_pc_2,
   output logic [4:0]  IF_ID_rs1_2,
   output logic [4:0]  IF_ID_rs2_2,
   output logic [4:0]  IF_ID_rd_2
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
   localparam logic [CNT_W-1:0] C_READY_MAX = CNT_W'(DEPTH - 2);

   logic [31:0]      r_mem_pc   [DEPTH];
   logic [31:0]      r_mem_inst [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             r_v1;
   logic [31:0]      r_inst1;
   logic [31:0]      r_pc1;
   logic             r_v2;
   logic [31:0]      r_inst2;
   logic [31:0]      r_pc2;

   logic [PTR_W-1:0] w_head_p1;
   logic [PTR_W-1:0] w_tail_p1;
   logic             w_push_1;
   logic             w_push_2;
   logic             w_issue_en;
   logic             w_pop_1;
   logic             w_pop_2;
   logic             w_pair_ok;
   logic [1:0]       w_n_push;
   logic [1:0]       w_n_pop;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_head_p1 = r_head + 1'b1;
   assign w_tail_p1 = r_tail + 1'b1;

   // Registered count only, so a pop never shortens the fetch ready path.
   assign fetch_ready = (r_count <= C_READY_MAX);

`ifdef IBUF_PAIR_CHECK_EN
   logic [4:0] w_head_rd;
   logic [4:0] w_next_rs1;
   logic [4:0] w_next_rs2;

   assign w_head_rd  = r_mem_inst[r_head][11:7];
   assign w_next_rs1 = r_mem_inst[w_head_p1][19:15];
   assign w_next_rs2 = r_mem_inst[w_head_p1][24:20];
   assign w_pair_ok  = (w_head_rd == 5'd0) ||
                       ((w_head_rd != w_next_rs1) && (w_head_rd != w_next_rs2));
`else
   assign w_pair_ok = 1'b1;
`endif

   always_comb begin
      w_push_1    = fetch_ready && fetch_valid_1 && !flush;
      w_push_2    = w_push_1 && fetch_valid_2;
      w_issue_en  = !id_stall && !flush;
      w_pop_1     = w_issue_en && (r_count >= C_ONE);
      w_pop_2     = w_pop_1 && (r_count >= C_TWO) && w_pair_ok;
      w_n_push    = {1'b0, w_push_1} + {1'b0, w_push_2};
      w_n_pop     = {1'b0, w_pop_1} + {1'b0, w_pop_2};
      w_count_nxt = r_count + CNT_W'(w_n_push) - CNT_W'(w_n_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_n_pop);
         r_tail  <= r_tail + PTR_W'(w_n_push);
         r_count <= w_count_nxt;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (w_push_1) begin
         r_mem_pc[r_tail]   <= fetch_pc_1;
         r_mem_inst[r_tail] <= fetch_inst_1;
      end
      if (w_push_2) begin
         r_mem_pc[w_tail_p1]   <= fetch_pc_2;
         r_mem_inst[w_tail_p1] <= fetch_inst_2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1    <= 1'b0;
         r_inst1 <= '0;
         r_pc1   <= '0;
         r_v2    <= 1'b0;
         r_inst2 <= '0;
         r_pc2   <= '0;
      end else if (flush) begin
         r_v1    <= 1'b0;
         r_inst1 <= '0;
         r_pc1   <= '0;
         r_v2    <= 1'b0;
         r_inst2 <= '0;
         r_pc2   <= '0;
      end else if (!id_stall) begin
         if (w_pop_1) begin
            r_v1    <= 1'b1;
            r_inst1 <= r_mem_inst[r_head];
            r_pc1   <= r_mem_pc[r_head];
         end else begin
            r_v1    <= 1'b0;
            r_inst1 <= '0;
            r_pc1   <= '0;
         end
         if (w_pop_2) begin
            r_v2    <= 1'b1;
            r_inst2 <= r_mem_inst[w_head_p1];
            r_pc2   <= r_mem_pc[w_head_p1];
         end else begin
            r_v2    <= 1'b0;
            r_inst2 <= '0;
            r_pc2   <= '0;
         end
      end
   end

   assign IF_ID_valid_1 = r_v1;
   assign IF_ID_inst_1  = r_inst1;
   assign IF_ID_pc_1    = r_pc1;
   assign IF_ID_rs1_1   = r_inst1[19:15];
   assign IF_ID_rs2_1   = r_inst1[24:20];
   assign IF_ID_rd_1    = r_inst1[11:7];
   assign IF_ID_valid_2 = r_v2;
   assign IF_ID_inst_2  = r_inst2;
   assign IF_ID_pc_2    = r_pc2;
   assign IF_ID_rs1_2   = r_inst2[19:15];
   assign IF_ID_rs2_2   = r_inst2[24:20];
   assign IF_ID_rd_2    = r_inst2[11:7];

endmodule

// File: tb/tb_if_id_issue_buffer.sv
// Scoreboard bench for if_id_issue_buffer: directed vectors plus a short random fetch/stall run.
// Build with IBUF_PAIR_CHECK_EN defined to exercise the dependent-pair case.
module tb_if_id_issue_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid_1, fetch_valid_2;
   logic [31:0] fetch_inst_1, fetch_pc_1, fetch_inst_2, fetch_pc_2;
   logic        fetch_ready;
   logic        id_stall, flush;
   logic        IF_ID_valid_1, IF_ID_valid_2;
   logic [31:0] IF_ID_inst_1, IF_ID_pc_1, IF_ID_inst_2, IF_ID_pc_2;
   logic [4:0]  IF_ID_rs1_1, IF_ID_rs2_1, IF_ID_rd_1;
   logic [4:0]  IF_ID_rs1_2, IF_ID_rs2_2, IF_ID_rd_2;

   if_id_issue_buffer #(.DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid_1(fetch_valid_1), .fetch_inst_1(fetch_inst_1), .fetch_pc_1(fetch_pc_1),
      .fetch_valid_2(fetch_valid_2), .fetch_inst_2(fetch_inst_2), .fetch_pc_2(fetch_pc_2),
      .fetch_ready(fetch_ready), .id_stall(id_stall), .flush(flush),
      .IF_ID_valid_1(IF_ID_valid_1), .IF_ID_inst_1(IF_ID_inst_1), .IF_ID_pc_1(IF_ID_pc_1),
      .IF_ID_rs1_1(IF_ID_rs1_1), .IF_ID_rs2_1(IF_ID_rs2_1), .IF_ID_rd_1(IF_ID_rd_1),
      .IF_ID_valid_2(IF_ID_valid_2), .IF_ID_inst_2(IF_ID_inst_2), .IF_ID_pc_2(IF_ID_pc_2),
      .IF_ID_rs1_2(IF_ID_rs1_2), .IF_ID_rs2_2(IF_ID_rs2_2), .IF_ID_rd_2(IF_ID_rd_2)
   );

   always #5 clk = ~clk;

   // addi x1,x0,1 / addi x2,x0,2 / addi x5,x0,1 / add x6,x5,x5
   localparam logic [31:0] I_A    = 32'h0010_0093;
   localparam logic [31:0] I_B    = 32'h0020_0113;
   localparam logic [31:0] I_ADDI = 32'h0010_0293;
   localparam logic [31:0] I_ADD  = 32'h0052_8333;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_slot(input string tag, input logic [63:0] e, input logic [31:0] pc,
                             input logic [31:0] inst, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd);
      logic [31:0] ei;
      ei = e[31:0];
      check({tag, "_pc"}, pc, e[63:32]);
      check({tag, "_inst"}, inst, ei);
      check({tag, "_rs1"}, {27'd0, rs1}, {27'd0, ei[19:15]});
      check({tag, "_rs2"}, {27'd0, rs2}, {27'd0, ei[24:20]});
      check({tag, "_rd"}, {27'd0, rd}, {27'd0, ei[11:7]});
   endtask

   task automatic unexpected(input string tag, input logic [31:0] pc);
      n_vec++;
      n_err++;
      $display("FAIL %s: got issue of pc 0x%08h, expected nothing pending", tag, pc);
   endtask

   // Monitor: one compare set per edge that was allowed to issue.
   initial begin : monitor
      logic        iss, fl;
      logic [63:0] e;
      forever begin
         @(posedge clk);
         iss = rst_n && !id_stall && !flush;
         fl  = rst_n && flush;
         #1;
         if (fl) begin
            check("flush_v1", {31'd0, IF_ID_valid_1}, 32'd0);
            check("flush_v2", {31'd0, IF_ID_valid_2}, 32'd0);
         end
         if (iss) begin
            if (IF_ID_valid_1) begin
               if (exp_q.size() == 0) unexpected("slot1_extra", IF_ID_pc_1);
               else begin
                  e = exp_q.pop_front();
                  check_slot("slot1", e, IF_ID_pc_1, IF_ID_inst_1, IF_ID_rs1_1, IF_ID_rs2_1, IF_ID_rd_1);
               end
            end else begin
               check("idle1_pc", IF_ID_pc_1, 32'd0);
               check("idle1_inst", IF_ID_inst_1, 32'd0);
               check("idle1_v2", {31'd0, IF_ID_valid_2}, 32'd0);
            end
            if (IF_ID_valid_2) begin
               if (exp_q.size() == 0) unexpected("slot2_extra", IF_ID_pc_2);
               else begin
                  e = exp_q.pop_front();
                  check_slot("slot2", e, IF_ID_pc_2, IF_ID_inst_2, IF_ID_rs1_2, IF_ID_rs2_2, IF_ID_rd_2);
               end
            end else begin
               check("idle2_pc", IF_ID_pc_2, 32'd0);
               check("idle2_inst", IF_ID_inst_2, 32'd0);
               check("idle2_rd", {27'd0, IF_ID_rd_2}, 32'd0);
            end
         end
      end
   end

   task automatic fetch(input logic v1, input logic [31:0] pc1, input logic [31:0] i1,
                        input logic v2, input logic [31:0] pc2, input logic [31:0] i2);
      fetch_valid_1 = v1;
      fetch_pc_1    = pc1;
      fetch_inst_1  = i1;
      fetch_valid_2 = v2;
      fetch_pc_2    = pc2;
      fetch_inst_2  = i2;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
      exp_q.push_back({pc, inst});
   endtask

   // rd = x0 filler instructions: never block pairing
   function automatic logic [31:0] nopi(input logic [11:0] k);
      return {k, 20'h0_0013};
   endfunction

   initial begin : stim
      logic [31:0] pc_nxt;
      logic [31:0] i1, i2;
      logic        v2;
      fetch(1'b0, '0, '0, 1'b0, '0, '0);
      id_stall = 1'b0;
      flush    = 1'b0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #3;
      check("rst_ready", {31'd0, fetch_ready}, 32'd1);
      check("rst_v1", {31'd0, IF_ID_valid_1}, 32'd0);
      check("rst_v2", {31'd0, IF_ID_valid_2}, 32'd0);
      check("rst_pc1", IF_ID_pc_1, 32'd0);
      check("rst_inst2", IF_ID_inst_2, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // independent pair: both issue two edges after the push
      @(negedge clk);
      fetch(1'b1, 32'h0, I_A, 1'b1, 32'h4, I_B);
      push_exp(32'h0, I_A);
      push_exp(32'h4, I_B);
      @(negedge clk);
      fetch(1'b0, '0, '0, 1'b0, '0, '0);
      check("t1_ready_c2", {31'd0, fetch_ready}, 32'd1);
      @(negedge clk);
      check("t1_v1", {31'd0, IF_ID_valid_1}, 32'd1);
      check("t1_v2", {31'd0, IF_ID_valid_2}, 32'd1);
      check("t1_pc1", IF_ID_pc_1, 32'h0);
      check("t1_pc2", IF_ID_pc_2, 32'h4);
      @(negedge clk);
      check("t1_drain_v1", {31'd0, IF_ID_valid_1}, 32'd0);
      check("t1_drain_v2", {31'd0, IF_ID_valid_2}, 32'd0);
      check("t1_drain_ready", {31'd0, fetch_ready}, 32'd1);

      // RAW pair: addi x5 then add x6,x5,x5
      @(negedge clk);
      fetch(1'b1, 32'h100, I_ADDI, 1'b1, 32'h104, I_ADD);
      push_exp(32'h100, I_ADDI);
      push_exp(32'h104, I_ADD);
      @(negedge clk);
      fetch(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      check("t2_v1", {31'd0, IF_ID_valid_1}, 32'd1);
      check("t2_pc1", IF_ID_pc_1, 32'h100);
`ifdef IBUF_PAIR_CHECK_EN
      check("t2_v2_blocked", {31'd0, IF_ID_valid_2}, 32'd0);
      @(negedge clk);
      check("t2_next_v1", {31'd0, IF_ID_valid_1}, 32'd1);
      check("t2_next_pc1", IF_ID_pc_1, 32'h104);
      check("t2_next_v2", {31'd0, IF_ID_valid_2}, 32'd0);
`else
      check("t2_v2_paired", {31'd0, IF_ID_valid_2}, 32'd1);
      check("t2_pc2", IF_ID_pc_2, 32'h104);
      @(negedge clk);
      check("t2_next_v1", {31'd0, IF_ID_valid_1}, 32'd0);
`endif
      repeat (2) @(negedge clk);

      // fill to DEPTH under stall, then drain in order
      id_stall = 1'b1;
      fetch(1'b1, 32'h200, nopi(12'h1), 1'b0, '0, '0);
      push_exp(32'h200, nopi(12'h1));
      @(negedge clk);
      check("t3_ready_c1", {31'd0, fetch_ready}, 32'd1);
      fetch(1'b1, 32'h204, nopi(12'h2), 1'b0, '0, '0);
      push_exp(32'h204, nopi(12'h2));
      @(negedge clk);
      check("t3_ready_c2", {31'd0, fetch_ready}, 32'd1);
      fetch(1'b1, 32'h208, nopi(12'h3), 1'b1, 32'h20C, nopi(12'h4));
      push_exp(32'h208, nopi(12'h3));
      push_exp(32'h20C, nopi(12'h4));
      @(negedge clk);
      check("t3_ready_full", {31'd0, fetch_ready}, 32'd0);
      check("t3_stall_v1", {31'd0, IF_ID_valid_1}, 32'd0);
      fetch(1'b1, 32'h210, nopi(12'h5), 1'b1, 32'h214, nopi(12'h6));
      @(negedge clk);
      check("t3_ready_nooverflow", {31'd0, fetch_ready}, 32'd0);
      fetch(1'b0, '0, '0, 1'b0, '0, '0);
      id_stall = 1'b0;
      @(negedge clk);
      check("t3_rel_pc1", IF_ID_pc_1, 32'h200);
      check("t3_rel_pc2", IF_ID_pc_2, 32'h204);
      check("t3_rel_ready", {31'd0, fetch_ready}, 32'd1);
      @(negedge clk);
      check("t3_rel2_pc1", IF_ID_pc_1, 32'h208);
      check("t3_rel2_pc2", IF_ID_pc_2, 32'h20C);
      @(negedge clk);
      check("t3_empty_v1", {31'd0, IF_ID_valid_1}, 32'd0);

      // flush at count 3 with a same-cycle fetch
      id_stall = 1'b1;
      fetch(1'b1, 32'h300, nopi(12'h7), 1'b0, '0, '0);
      push_exp(32'h300, nopi(12'h7));
      @(negedge clk);
      fetch(1'b1, 32'h304, nopi(12'h8), 1'b1, 32'h308, nopi(12'h9));
      push_exp(32'h304, nopi(12'h8));
      push_exp(32'h308, nopi(12'h9));
      @(negedge clk);
      check("t4_ready_c3", {31'd0, fetch_ready}, 32'd0);
      flush = 1'b1;
      fetch(1'b1, 32'h30C, nopi(12'hA), 1'b1, 32'h310, nopi(12'hB));
      exp_q.delete();
      @(negedge clk);
      check("t4_flush_v1", {31'd0, IF_ID_valid_1}, 32'd0);
      check("t4_flush_v2", {31'd0, IF_ID_valid_2}, 32'd0);
      check("t4_flush_ready", {31'd0, fetch_ready}, 32'd1);
      flush    = 1'b0;
      id_stall = 1'b0;
      fetch(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      check("t4_after_v1", {31'd0, IF_ID_valid_1}, 32'd0);
      check("t4_after_ready", {31'd0, fetch_ready}, 32'd1);

      // asynchronous reset mid-operation with count 2 and valid outputs
      fetch(1'b1, 32'h400, nopi(12'h11), 1'b1, 32'h404, nopi(12'h12));
      push_exp(32'h400, nopi(12'h11));
      push_exp(32'h404, nopi(12'h12));
      @(negedge clk);
      fetch(1'b1, 32'h408, nopi(12'h13), 1'b1, 32'h40C, nopi(12'h14));
      push_exp(32'h408, nopi(12'h13));
      push_exp(32'h40C, nopi(12'h14));
      @(negedge clk);
      fetch(1'b0, '0, '0, 1'b0, '0, '0);
      id_stall = 1'b1;
      @(posedge clk);
      #2;
      check("t5_pre_v1", {31'd0, IF_ID_valid_1}, 32'd1);
      check("t5_pre_pc1", IF_ID_pc_1, 32'h400);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("t5_rst_v1", {31'd0, IF_ID_valid_1}, 32'd0);
      check("t5_rst_v2", {31'd0, IF_ID_valid_2}, 32'd0);
      check("t5_rst_pc1", IF_ID_pc_1, 32'd0);
      check("t5_rst_inst1", IF_ID_inst_1, 32'd0);
      check("t5_rst_pc2", IF_ID_pc_2, 32'd0);
      check("t5_rst_ready", {31'd0, fetch_ready}, 32'd1);
      @(negedge clk);
      rst_n    = 1'b1;
      id_stall = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_post_v1", {31'd0, IF_ID_valid_1}, 32'd0);
      check("t5_post_v2", {31'd0, IF_ID_valid_2}, 32'd0);

      // random fetch and stall; slot-2-only fetches must be ignored
      pc_nxt = 32'h1000;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         id_stall = ($urandom_range(0, 2) == 0);
         i1 = $urandom;
         i2 = $urandom;
         if (fetch_ready && ($urandom_range(0, 3) != 0)) begin
            v2 = 1'($urandom_range(0, 1));
            fetch(1'b1, pc_nxt, i1, v2, pc_nxt + 32'd4, i2);
            push_exp(pc_nxt, i1);
            if (v2) push_exp(pc_nxt + 32'd4, i2);
            pc_nxt = pc_nxt + (v2 ? 32'd8 : 32'd4);
         end else begin
            fetch(1'b0, pc_nxt, i1, 1'b1, pc_nxt + 32'd4, i2);
         end
      end
      @(negedge clk);
      fetch(1'b0, '0, '0, 1'b0, '0, '0);
      id_stall = 1'b0;
      repeat (8) @(negedge clk);
      check("t6_leftover", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
